cov_kernel_sched: RTL and testbench
===================================

Name: cov_kernel_sched

Overview:
Scheduler that shares one pipelined Q16 cubic covariance kernel among N_REQ requesters. It round-robin arbitrates scalar r_q16 requests and issues at most one per cycle into the kernel. Each issue carries a requester tag through a valid/tag delay line matched to the kernel latency. Results are captured into a response FIFO and returned with their requester ID over a valid/ready port. Credit-based issue guarantees the FIFO never overflows, so the kernel itself needs no stall.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 16, width of r_q16 operands (unsigned Q16)
KERN_LAT, 4, kernel latency in cycles (operand in cycle t, result valid on kern_ans_q16 in cycle t+KERN_LAT)
FIFO_DEPTH, 8, response FIFO depth; power of 2, must be >= KERN_LAT
ID_WIDTH, 2, requester ID width; must equal clog2(N_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  issue enable; low blocks new grants, in-flight work drains
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant; one-hot or zero
req_r_q16  in  N_REQ*DATA_WIDTH  packed operands; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
kern_r_q16  out  DATA_WIDTH  operand to kernel
kern_ans_q16  in  32  kernel result, signed Q16
rsp_valid  out  1  response available (FIFO not empty)
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_WIDTH  requester ID of head response
rsp_ans_q16  out  32  head response value
idle  out  1  no request in flight and FIFO empty
issue_cnt  out  32  total issues since reset; wraps modulo 2^32

Behaviour:
- Reset (rst high at clock edge):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_ans_q16=0, idle=1, issue_cnt=0.
  - Round-robin pointer=0, valid/tag pipe cleared, FIFO emptied, credit count=0.
  - Reset mid-operation drops all in-flight and buffered results. Kernel outputs in the following KERN_LAT cycles are ignored because the valid pipe is already clear.
- Credit count = in-flight + FIFO occupancy, registered.
- Issue condition: en && count < FIFO_DEPTH && any req_valid. Uses the registered count only, so there is no combinational path rsp_ready -> req_ready.
- Arbitration (combinational):
  - Grant goes to the first valid requester at index >= pointer, wrapping.
  - req_ready[g]=1 only for the granted g, and only when the issue condition holds.
  - Handshake is req_valid[g] && req_ready[g].
  - On issue, pointer <= (g+1) mod N_REQ; otherwise pointer holds.
- kern_r_q16 = granted operand in the issue cycle, else 0.
- Valid/tag pipe: KERN_LAT-deep shift register of {valid, id}, shifting every cycle with no stall. The entry leaving the pipe in cycle t+KERN_LAT writes {id, kern_ans_q16} into the FIFO at the end of that cycle.
- FIFO: registered, not fall-through. rsp_valid first rises in cycle t+KERN_LAT+1, so minimum request-to-response latency is KERN_LAT+1. Head is popped when rsp_valid && rsp_ready.
- Count update:
  - +1 on issue, -1 on pop.
  - Issue and pop in the same cycle leave the count unchanged.
  - A pop when count == FIFO_DEPTH enables issue in the next cycle.
- FIFO write and pop in the same cycle are legal, including when the FIFO is full at the start of the cycle. Overflow is impossible by construction; verification asserts this.
- Response order = issue order, regardless of requester.
- en falling: no grant from that cycle; in-flight results are still delivered.
- idle = (count == 0), registered.
- issue_cnt increments by 1 on each issue.

Decomposition:
- Package cov_sched_pkg holds:
  - default KERN_LAT=4 and the Q16 fraction-bits constant (16);
  - a clog2 function for ID_WIDTH checking;
  - the response entry layout {id, ans_q16}, width ID_WIDTH+32.
- Sub-module cov_rsp_fifo: synchronous FIFO, parameterised width and depth, synchronous active-high reset, push/pop/full/empty/count.
- Arbiter, credit logic and tag pipe live in the top module.

Test Plan:
- Single request: req_valid[2]=1, req_r_q16[2]=0x8000 in cycle 0, rsp_ready=1.
  -> req_ready=4'b0100 and kern_r_q16=0x8000 in cycle 0.
  -> rsp_valid in cycle 5 with rsp_id=2 and rsp_ans_q16 equal to kern_ans_q16 as driven in cycle 4; idle back to 1 in cycle 6.
- All four valid continuously, rsp_ready=1.
  -> grants 0,1,2,3,0,1,... one per cycle.
  -> rsp_id sequence identical, 1 response per cycle from cycle 5, issue_cnt=N after N cycles.
- Backpressure: rsp_ready=0, req_valid[0] held high.
  -> exactly 8 issues, then req_ready=0.
  -> raise rsp_ready: one pop per cycle, issue resumes the cycle after the first pop, no lost or duplicated IDs over 100 transactions.
- en dropped after 3 issues with requesters still valid.
  -> no further req_ready; the 3 in-flight results are delivered; idle=1 after the last pop.
- rst asserted for 1 cycle with 3 in flight and 2 in FIFO.
  -> next cycle rsp_valid=0, idle=1, issue_cnt=0; no response in the next 6 cycles.
  -> after release with all requesters valid, the first grant goes to requester 0.
- Mixed sparse requests from requesters 1 and 3 with random rsp_ready.
  -> scoreboard matches each {id, ans} in order; count never exceeds 8; FIFO overflow assertion never fires.

Source files
------------

// File: rtl/cov_sched_pkg.sv
// Shared constants and helpers for the covariance-kernel scheduler.
package cov_sched_pkg;

    // Kernel pipeline depth assumed when the instantiator does not override it.
    localparam int KERN_LAT_DEFAULT = 4;

    // Number of fractional bits in the Q16 fixed-point format.
    localparam int Q16_FRAC_BITS = 16;

    // Width of the signed Q16 kernel result.
    localparam int ANS_WIDTH = 32;

    // Ceiling log2, used to confirm the requester ID width matches N_REQ.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A response entry is packed as {id, ans_q16}; this gives its width.
    function automatic int rsp_entry_width(input int id_width);
        return id_width + ANS_WIDTH;
    endfunction

    // Response entry layout for the default four-requester configuration.
    typedef struct packed {
        logic [1:0]           id;
        logic [ANS_WIDTH-1:0] ans_q16;
    } rsp_entry_default_t;

endpackage

// File: rtl/cov_rsp_fifo.sv
// Registered (non fall-through) synchronous FIFO. The head entry is held in
// an output register that is preloaded from the RAM at the next read address,
// with a bypass for the entry being written when it becomes the new head.
module cov_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    // A write into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push && ((count_reg != DEPTH_CNT) || do_pop);

    // Next occupancy and read address.
    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next == '0) begin
                dout_reg <= '0;
            end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                dout_reg <= din;
            end else begin
                dout_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign dout  = dout_reg;
    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/cov_kernel_sched.sv
// Shares one pipelined Q16 cubic covariance kernel among N_REQ requesters:
// round-robin arbitration, a tag pipe matched to the kernel latency, and a
// response FIFO whose space is reserved by credits at issue time so the
// kernel never has to stall.
module cov_kernel_sched
    import cov_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int KERN_LAT   = KERN_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_r_q16,
    output logic [DATA_WIDTH-1:0]       kern_r_q16,
    input  logic [ANS_WIDTH-1:0]        kern_ans_q16,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [ANS_WIDTH-1:0]        rsp_ans_q16,
    output logic                        idle,
    output logic [31:0]                 issue_cnt
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = rsp_entry_width(ID_WIDTH);
    localparam logic [CNT_W-1:0]    CREDIT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(N_REQ - 1);

    if (ID_WIDTH != clog2(N_REQ)) begin : g_bad_id_width
        $error("cov_kernel_sched: ID_WIDTH must equal clog2(N_REQ)");
    end

    logic [ID_WIDTH-1:0]   ptr_reg;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  idle_reg;
    logic [31:0]           issue_cnt_reg;
    logic [DATA_WIDTH-1:0] req_op [N_REQ];
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   cand;
    logic                  issue;
    logic                  pop;
    logic                  pipe_valid_reg [KERN_LAT];
    logic [ID_WIDTH-1:0]   pipe_id_reg [KERN_LAT];
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  unused_fifo_status;

    // Unpack the per-requester operands and drive the one-hot grant.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_op[gi]    = req_r_q16[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[gi] = issue && (grant_idx == ID_WIDTH'(gi));
    end

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(ptr_reg) + k >= N_REQ) begin
                cand = ID_WIDTH'(int'(ptr_reg) + k - N_REQ);
            end else begin
                cand = ID_WIDTH'(int'(ptr_reg) + k);
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Issue only from the registered credit count, keeping rsp_ready off the grant path.
    assign issue      = !rst && en && (count_reg < CREDIT_MAX) && grant_found;
    assign ptr_next   = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    assign kern_r_q16 = issue ? req_op[grant_idx] : '0;

    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;

    // Credits cover both in-flight kernel work and buffered responses.
    always_comb begin
        count_next = count_reg;
        if (issue && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!issue && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Arbiter pointer, credit count, idle flag and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            idle_reg      <= 1'b1;
            issue_cnt_reg <= '0;
        end else begin
            if (issue) begin
                ptr_reg       <= ptr_next;
                issue_cnt_reg <= issue_cnt_reg + 32'd1;
            end
            count_reg <= count_next;
            idle_reg  <= (count_next == '0);
        end
    end

    // First tag stage captures the issue of this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg[0] <= 1'b0;
            pipe_id_reg[0]    <= '0;
        end else begin
            pipe_valid_reg[0] <= issue;
            pipe_id_reg[0]    <= grant_idx;
        end
    end

    // Remaining tag stages shift unconditionally, mirroring the kernel pipeline.
    for (genvar gi = 1; gi < KERN_LAT; gi++) begin : g_pipe
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_valid_reg[gi] <= 1'b0;
                pipe_id_reg[gi]    <= '0;
            end else begin
                pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                pipe_id_reg[gi]    <= pipe_id_reg[gi-1];
            end
        end
    end

    assign fifo_din = {pipe_id_reg[KERN_LAT-1], kern_ans_q16};

    cov_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_valid_reg[KERN_LAT-1]),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Credits already bound occupancy, so the FIFO status flags are informational only.
    assign unused_fifo_status = ^{fifo_full, fifo_count};

    assign rsp_id      = fifo_dout[ENTRY_W-1 -: ID_WIDTH];
    assign rsp_ans_q16 = fifo_dout[ANS_WIDTH-1:0];
    assign idle        = idle_reg;
    assign issue_cnt   = issue_cnt_reg;

endmodule

// File: tb/tb_cov_kernel_sched.sv
// Self-checking bench for cov_kernel_sched: directed phases with random
// operands and handshakes, checked every cycle against a queue-based model.
module tb_cov_kernel_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_r_q16;
    logic [DW-1:0]   kern_r_q16;
    logic [31:0]     kern_ans_q16;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_ans_q16;
    logic            idle;
    logic [31:0]     issue_cnt;

    logic [DW-1:0]   ops [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_ops
        assign req_r_q16[gi*DW +: DW] = ops[gi];
    end

    cov_kernel_sched #(
        .N_REQ(N), .DATA_WIDTH(DW), .KERN_LAT(L), .FIFO_DEPTH(D), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_r_q16(req_r_q16),
        .kern_r_q16(kern_r_q16), .kern_ans_q16(kern_ans_q16),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_ans_q16(rsp_ans_q16), .idle(idle), .issue_cnt(issue_cnt)
    );

    // Arbitrary but operand-dependent cubic-style kernel result.
    function automatic logic [31:0] kern_fn(input logic [DW-1:0] r);
        logic [63:0] p;
        p = 64'(r) * 64'(r) * 64'(r);
        return p[63:32] ^ {r, 16'h5A3C};
    endfunction

    // Emulated kernel: operand in cycle t, result on kern_ans_q16 in cycle t+L.
    logic [DW-1:0] kpipe [L];
    always @(posedge clk) begin
        kpipe[0] <= kern_r_q16;
        for (int i = 1; i < L; i++) kpipe[i] <= kpipe[i-1];
    end
    assign kern_ans_q16 = kern_fn(kpipe[L-1]);

    // Reference model: outstanding requests in issue order, each with the cycle
    // at which it becomes visible at the response port.
    typedef struct {
        int          id;
        logic [31:0] ans;
        int          ready_cyc;
    } exp_t;

    exp_t        q[$];
    int          m_ptr;
    logic [31:0] m_issue_cnt;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check all outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_kern;
        int            g;
        int            n_ready;
        bit            exp_valid;
        bit            do_pop;
        @(negedge clk);
        exp_ready = '0;
        exp_kern  = '0;
        g         = -1;
        exp_valid = 1'b0;
        if (!rst && en && q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_kern     = ops[g];
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("kern_r_q16", 64'(kern_r_q16), 64'(exp_kern));
        if (!rst) begin
            exp_valid = (q.size() > 0) && (q[0].ready_cyc <= cyc);
            n_ready = 0;
            foreach (q[i]) if (q[i].ready_cyc <= cyc) n_ready++;
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("rsp_ans_q16", 64'(rsp_ans_q16), 64'(q[0].ans));
            end
            chk("idle", 64'(idle), 64'(q.size() == 0));
            chk("issue_cnt", 64'(issue_cnt), 64'(m_issue_cnt));
            chk("fifo_level", 64'(dut.fifo_count), 64'(n_ready));
        end
        do_pop = exp_valid && rsp_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr       = 0;
            m_issue_cnt = '0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{g, kern_fn(ops[g]), cyc + L + 1});
                m_ptr       = (g + 1) % N;
                m_issue_cnt = m_issue_cnt + 32'd1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) ops[i] = DW'($urandom);
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            rand_ops();
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc         = 0;
        m_ptr       = 0;
        m_issue_cnt = '0;
        rst         = 1'b1;
        en          = 1'b0;
        req_valid   = '0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < N; i++) ops[i] = '0;

        // Reset and its output state.
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_ans", 64'(rsp_ans_q16), 64'd0);
        chk("reset_idle", 64'(idle), 64'd1);
        tick();

        // Single request from requester 2.
        en        = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        ops[2]    = 16'h8000;
        tick();
        req_valid = '0;
        for (int i = 0; i < 8; i++) tick();

        // All requesters valid continuously.
        req_valid = 4'b1111;
        for (int i = 0; i < 24; i++) begin
            rand_ops();
            tick();
        end
        drain(12);

        // Backpressure: fill credits, then release and stream 100 transactions.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            rand_ops();
            tick();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            tick();
        end
        drain(14);

        // Enable dropped after three issues.
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            tick();
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        req_valid = '0;
        tick();

        // Reset with work both in flight and buffered.
        rsp_ready = 1'b0;
        en        = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            tick();
        end
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("midrst_rsp_id", 64'(rsp_id), 64'd0);
        chk("midrst_rsp_ans", 64'(rsp_ans_q16), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            tick();
        end
        drain(14);

        // Sparse traffic from requesters 1 and 3 with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid    = '0;
            req_valid[1] = ($urandom_range(0, 2) == 0);
            req_valid[3] = ($urandom_range(0, 2) == 0);
            rsp_ready    = $urandom_range(0, 1) != 0;
            en           = $urandom_range(0, 9) != 0;
            tick();
        end
        en = 1'b1;
        drain(20);
        chk("final_idle", 64'(idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
